sharp_update_scheduler: RTL and testbench

- Controller that decides which LS013B7DH01 line the line-writer engine (SPI mode/address/data/dummy sequencer) transmits next.
- Keeps a dirty-line bitmap fed by the frame-buffer side and services dirty lines round-robin.
- Also issues all-clear commands and generates the VCOM polarity used for both the M1 mode bit and EXTCOMIN.
- Sits between host/frame-buffer logic and the line writer; one writer transaction in flight at a time.

---
 rtl/sharp_update_scheduler_if.sv | 26 ++
 rtl/sharp_update_scheduler.sv | 136 +++++++++++++
 tb/tb_sharp_update_scheduler.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sharp_update_scheduler_if.sv
// Mark inputs from the frame-buffer side and the command handshake to the LS013B7DH01 line writer.
interface sharp_update_scheduler_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              mark_valid;
  logic [ADDR_W-1:0] mark_line;
  logic              mark_all;
  logic              clear_req;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_mode;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_done;
  logic              vcom;
  logic              idle;

  modport master (
    input  mark_valid, mark_line, mark_all, clear_req, cmd_ready, cmd_done,
    output cmd_valid, cmd_mode, cmd_addr, vcom, idle
  );

  modport slave (
    output mark_valid, mark_line, mark_all, clear_req, cmd_ready, cmd_done,
    input  cmd_valid, cmd_mode, cmd_addr, vcom, idle
  );
endinterface

// File: rtl/sharp_update_scheduler.sv
// Chooses the next LS013B7DH01 command: all-clear first, then dirty lines round-robin.
// Also free-runs the VCOM polarity used for the M1 bit and EXTCOMIN.
module sharp_update_scheduler #(
  parameter int unsigned NUM_LINES = 168,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned VCOM_DIV  = 200000
) (
  input  logic                     clk_12mhz,
  input  logic                     rst_n,
  sharp_update_scheduler_if.master bus
);

  localparam int unsigned CNT_W = $clog2(VCOM_DIV);

  localparam logic [1:0] ST_SCAN      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_CLR_ISSUE = 2'd2;
  localparam logic [1:0] ST_WAIT      = 2'd3;

  logic [1:0]           state, state_nxt;
  logic [ADDR_W-1:0]    ptr, ptr_nxt;
  logic [NUM_LINES-1:0] dirty, dirty_nxt;
  logic                 clear_pending, clear_nxt;
  logic                 cmd_valid_q, valid_nxt;
  logic [2:0]           cmd_mode_q, mode_nxt;
  logic [ADDR_W-1:0]    cmd_addr_q, addr_nxt;
  logic                 dirty_at_ptr;
  logic                 handshake;
  logic [CNT_W-1:0]     vcom_cnt;
  logic                 vcom_q;

  // Free-running VCOM divider, unrelated to the command flow.
  always_ff @(posedge clk_12mhz or negedge rst_n) begin
    if (!rst_n) begin
      vcom_cnt <= '0;
      vcom_q   <= 1'b0;
    end else if (vcom_cnt == CNT_W'(VCOM_DIV - 1)) begin
      vcom_cnt <= '0;
      vcom_q   <= ~vcom_q;
    end else begin
      vcom_cnt <= vcom_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_12mhz or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_SCAN;
      ptr           <= ADDR_W'(1);
      dirty         <= '0;
      clear_pending <= 1'b0;
      cmd_valid_q   <= 1'b0;
      cmd_mode_q    <= 3'b000;
      cmd_addr_q    <= '0;
    end else begin
      state         <= state_nxt;
      ptr           <= ptr_nxt;
      dirty         <= dirty_nxt;
      clear_pending <= clear_nxt;
      cmd_valid_q   <= valid_nxt;
      cmd_mode_q    <= mode_nxt;
      cmd_addr_q    <= addr_nxt;
    end
  end

  assign handshake = cmd_valid_q & bus.cmd_ready;

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    dirty_nxt    = dirty;
    clear_nxt    = clear_pending;
    valid_nxt    = cmd_valid_q;
    mode_nxt     = cmd_mode_q;
    addr_nxt     = cmd_addr_q;
    dirty_at_ptr = 1'b0;

    for (int i = 0; i < int'(NUM_LINES); i++) begin
      if (ptr == ADDR_W'(i + 1)) dirty_at_ptr = dirty[i];
    end

    case (state)
      ST_SCAN: begin
        // Pointer steps every scan cycle so worst-case service latency is one pass.
        ptr_nxt = (ptr == ADDR_W'(NUM_LINES)) ? ADDR_W'(1) : ptr + ADDR_W'(1);
        if (clear_pending) begin
          valid_nxt = 1'b1;
          mode_nxt  = {1'b1, vcom_q, 1'b0};
          addr_nxt  = '0;
          state_nxt = ST_CLR_ISSUE;
        end else if (dirty_at_ptr) begin
          valid_nxt = 1'b1;
          mode_nxt  = {1'b0, vcom_q, 1'b1};
          addr_nxt  = ptr;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (handshake) begin
          valid_nxt = 1'b0;
          state_nxt = ST_WAIT;
          for (int i = 0; i < int'(NUM_LINES); i++) begin
            if (cmd_addr_q == ADDR_W'(i + 1)) dirty_nxt[i] = 1'b0;
          end
        end
      end
      ST_CLR_ISSUE: begin
        if (handshake) begin
          valid_nxt = 1'b0;
          state_nxt = ST_WAIT;
          dirty_nxt = '0;
          clear_nxt = 1'b0;
        end
      end
      ST_WAIT: begin
        if (bus.cmd_done) state_nxt = ST_SCAN;
      end
      default: state_nxt = ST_SCAN;
    endcase

    // New marks are applied last so they survive a same-cycle handshake clear.
    if (bus.mark_all) dirty_nxt = '1;
    if (bus.mark_valid) begin
      for (int i = 0; i < int'(NUM_LINES); i++) begin
        if (bus.mark_line == ADDR_W'(i + 1)) dirty_nxt[i] = 1'b1;
      end
    end
    if (bus.clear_req) clear_nxt = 1'b1;
  end

  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_mode  = cmd_mode_q;
  assign bus.cmd_addr  = cmd_addr_q;
  assign bus.vcom      = vcom_q;
  assign bus.idle      = (state == ST_SCAN) & ~|dirty & ~clear_pending & ~cmd_valid_q;

endmodule

// File: tb/tb_sharp_update_scheduler.sv
// Scoreboard bench for sharp_update_scheduler: a line-set reference model predicts each command,
// a writer model answers the handshake, and a monitor compares every offered command.
module tb_sharp_update_scheduler;
  localparam int unsigned NUM_LINES = 168;
  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned VDIV      = 10;

  typedef struct packed {
    logic [2:0]        mode;
    logic [ADDR_W-1:0] addr;
  } cmd_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sharp_update_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

  sharp_update_scheduler #(
    .NUM_LINES(NUM_LINES),
    .ADDR_W   (ADDR_W),
    .VCOM_DIV (VDIV)
  ) dut (
    .clk_12mhz(clk),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- line writer model ----------------
  int   ready_pct  = 100;
  int   done_delay = 2;
  bit   manual     = 1'b0;
  logic man_ready  = 1'b0;
  logic man_done   = 1'b0;
  logic auto_ready = 1'b0;
  logic auto_done  = 1'b0;
  bit   w_prev_v   = 1'b0;
  bit   w_busy     = 1'b0;
  int   w_cnt      = 0;

  assign bus.cmd_ready = manual ? man_ready : auto_ready;
  assign bus.cmd_done  = auto_done | man_done;

  // A falling cmd_valid outside reset means the command was taken on the previous edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      w_prev_v   = 1'b0;
      w_busy     = 1'b0;
      auto_done  = 1'b0;
      auto_ready = 1'b0;
    end else begin
      auto_done = 1'b0;
      if (w_prev_v && !bus.cmd_valid) begin
        w_busy = 1'b1;
        w_cnt  = done_delay;
      end else if (w_busy) begin
        if (w_cnt <= 1) begin
          auto_done = 1'b1;
          w_busy    = 1'b0;
        end else begin
          w_cnt--;
        end
      end
      w_prev_v   = bus.cmd_valid;
      auto_ready = (int'($urandom_range(99)) < ready_pct);
    end
  end

  // ---------------- reference model ----------------
  // Set of lines awaiting refresh, a pending clear flag, and a scan position that
  // moves one line per cycle while the scheduler is looking for work.
  bit   want [1:NUM_LINES];
  bit   clr_m    = 1'b0;
  int   pos      = 1;
  int   phase    = 0;   // 0 looking, 1 offered, 2 writer busy
  bit   off_clr  = 1'b0;
  int   off_line = 0;
  int   n_edges  = 0;
  cmd_t exp_q [$];
  cmd_t log_q [$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (want[i]) want[i] = 1'b0;
      clr_m   = 1'b0;
      pos     = 1;
      phase   = 0;
      n_edges = 0;
      exp_q.delete();
    end else begin
      cmd_t e;
      bit   pol;
      pol = ((n_edges / VDIV) % 2) == 1;
      n_edges++;
      if (phase == 0) begin
        if (clr_m) begin
          e.mode = {1'b1, pol, 1'b0};
          e.addr = '0;
          exp_q.push_back(e);
          off_clr = 1'b1;
          phase   = 1;
        end else if (want[pos]) begin
          e.mode = {1'b0, pol, 1'b1};
          e.addr = ADDR_W'(pos);
          exp_q.push_back(e);
          off_clr  = 1'b0;
          off_line = pos;
          phase    = 1;
        end
        pos = (pos % NUM_LINES) + 1;
      end else if (phase == 1) begin
        if (bus.cmd_ready) begin
          if (off_clr) begin
            foreach (want[i]) want[i] = 1'b0;
            clr_m = 1'b0;
          end else begin
            want[off_line] = 1'b0;
          end
          phase = 2;
        end
      end else if (bus.cmd_done) begin
        phase = 0;
      end
      if (bus.mark_all) foreach (want[i]) want[i] = 1'b1;
      if (bus.mark_valid && bus.mark_line >= 1 && bus.mark_line <= NUM_LINES)
        want[int'(bus.mark_line)] = 1'b1;
      if (bus.clear_req) clr_m = 1'b1;
    end
  end

  // ---------------- monitor ----------------
  bit   m_prev_v = 1'b0;
  cmd_t held;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_prev_v = 1'b0;
    end else begin
      cmd_t cur, e;
      int   nwant;
      nwant = 0;
      foreach (want[i]) if (want[i]) nwant++;
      chk("vcom", 32'(bus.vcom), 32'((n_edges / VDIV) % 2));
      chk("idle", 32'(bus.idle), 32'(phase == 0 && !clr_m && nwant == 0));
      cur.mode = bus.cmd_mode;
      cur.addr = bus.cmd_addr;
      if (bus.cmd_valid && !m_prev_v) begin
        log_q.push_back(cur);
        if (exp_q.size() == 0) begin
          chk("unexpected_cmd", 32'(bus.cmd_valid), 0);
        end else begin
          e = exp_q.pop_front();
          chk("cmd_mode", 32'(cur.mode), 32'(e.mode));
          chk("cmd_addr", 32'(cur.addr), 32'(e.addr));
        end
        held = cur;
      end else if (bus.cmd_valid) begin
        chk("payload_stable", 32'({cur.mode, cur.addr}), 32'({held.mode, held.addr}));
      end
      if (exp_q.size() != 0) begin
        chk("cmd_missing", 32'(exp_q.size()), 0);
        exp_q.delete();
      end
      m_prev_v = bus.cmd_valid;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    int c = 0;
    while (!bus.idle && c < max_cyc) begin
      tick();
      c++;
    end
    chk(name, 32'(bus.idle), 1);
  endtask

  task automatic wait_offer(input logic [ADDR_W-1:0] a, input string name);
    int c = 0;
    while (!(bus.cmd_valid && bus.cmd_addr == a) && c < 400) begin
      tick();
      c++;
    end
    chk(name, 32'(bus.cmd_valid && bus.cmd_addr == a), 1);
  endtask

  task automatic mark(input int line);
    bus.mark_valid = 1'b1;
    bus.mark_line  = ADDR_W'(line);
    tick();
    bus.mark_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_valid"}, 32'(bus.cmd_valid), 0);
    chk({tag, "_cmd_mode"},  32'(bus.cmd_mode), 0);
    chk({tag, "_cmd_addr"},  32'(bus.cmd_addr), 0);
    chk({tag, "_vcom"},      32'(bus.vcom), 0);
    chk({tag, "_idle"},      32'(bus.idle), 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nbad;
    int n7;
    bus.mark_valid = 1'b0;
    bus.mark_line  = '0;
    bus.mark_all   = 1'b0;
    bus.clear_req  = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) tick();
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // Full frame: mark_all lands on edge 168 so the scan pointer is back at line 1.
    repeat (167) tick();
    log_q.delete();
    bus.mark_all = 1'b1;
    tick();
    bus.mark_all = 1'b0;
    wait_idle(5000, "frame_idle");
    chk("frame_count", 32'(log_q.size()), 168);
    nbad = 0;
    foreach (log_q[i])
      if (log_q[i].addr != ADDR_W'(i + 1) || log_q[i].mode[2] || !log_q[i].mode[0]) nbad++;
    chk("frame_order", 32'(nbad), 0);

    // Single update with a slow writer.
    log_q.delete();
    done_delay = 200;
    mark(5);
    wait_idle(1000, "single_idle");
    chk("single_count", 32'(log_q.size()), 1);
    if (log_q.size() > 0) begin
      chk("single_addr", 32'(log_q[0].addr), 5);
      chk("single_m2m0", 32'({log_q[0].mode[2], log_q[0].mode[0]}), 32'(2'b01));
    end

    // Clear requested alongside line marks takes priority and wipes them.
    log_q.delete();
    done_delay = 3;
    manual     = 1'b1;
    man_ready  = 1'b0;
    bus.clear_req = 1'b1;
    mark(10);
    bus.clear_req = 1'b0;
    mark(20);
    repeat (5) tick();
    manual = 1'b0;
    wait_idle(1000, "clear_idle");
    chk("clear_count", 32'(log_q.size()), 1);
    if (log_q.size() > 0) begin
      chk("clear_m2m0", 32'({log_q[0].mode[2], log_q[0].mode[0]}), 32'(2'b10));
      chk("clear_addr", 32'(log_q[0].addr), 0);
    end

    // Backpressure on line 7, then a re-mark in the handshake cycle.
    log_q.delete();
    done_delay = 2;
    manual     = 1'b1;
    man_ready  = 1'b0;
    mark(7);
    wait_offer(ADDR_W'(7), "bp_offer");
    repeat (50) tick();
    chk("bp_still_valid", 32'(bus.cmd_valid), 1);
    man_ready      = 1'b1;
    bus.mark_valid = 1'b1;
    bus.mark_line  = ADDR_W'(7);
    tick();
    man_ready      = 1'b0;
    bus.mark_valid = 1'b0;
    manual         = 1'b0;
    wait_idle(1000, "bp_idle");
    n7 = 0;
    foreach (log_q[i]) if (log_q[i].addr == ADDR_W'(7)) n7++;
    chk("bp_line7_twice", 32'(n7), 2);
    chk("bp_count", 32'(log_q.size()), 2);

    // Out-of-range line numbers are ignored.
    log_q.delete();
    mark(0);
    mark(NUM_LINES + 1);
    repeat (2 * NUM_LINES) tick();
    chk("oor_count", 32'(log_q.size()), 0);
    chk("oor_idle", 32'(bus.idle), 1);

    // Reset while a command is offered; a stale cmd_done afterwards is ignored.
    manual    = 1'b1;
    man_ready = 1'b0;
    mark(30);
    wait_offer(ADDR_W'(30), "rst_offer");
    repeat (3) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    check_reset_outputs("midrst");
    log_q.delete();
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    repeat (2 * NUM_LINES) tick();
    chk("midrst_no_cmd", 32'(log_q.size()), 0);
    manual = 1'b0;

    // Randomized traffic against the reference model.
    ready_pct = 70;
    for (int c = 0; c < 1500; c++) begin
      int unsigned r;
      r = $urandom_range(99);
      bus.mark_valid = (r < 15);
      bus.mark_line  = ADDR_W'($urandom_range(NUM_LINES + 3));
      bus.mark_all   = (r == 99) && ($urandom_range(3) == 0);
      bus.clear_req  = (r >= 96 && r < 98);
      done_delay     = int'($urandom_range(6, 1));
      tick();
    end
    bus.mark_valid = 1'b0;
    bus.mark_all   = 1'b0;
    bus.clear_req  = 1'b0;
    ready_pct      = 100;
    wait_idle(20000, "random_idle");
    chk("exp_q_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
